// File: rtl/upc_pkg.sv
// upc_pkg: shared types and helpers for the UPC checkout block.
//   state_t          - checkout FSM state encoding (IDLE/SCAN/DONE)
//   DEF_DISC_MASK    - default discount lookup (P | (U & C) for {U,P,C})
//   DEF_STOLEN_MASK  - default stolen lookup (~P & (U | ~C) for {U,P,C})
//   classify()       - mask lookup returning {disc, stolen}
package upc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] DEF_DISC_MASK   = 8'hEC;
  localparam logic [7:0] DEF_STOLEN_MASK = 8'h31;

  // The lookup function works on the widest supported code; callers
  // zero-extend their code and masks to these widths.
  localparam int MAX_CODE_W = 8;
  localparam int MASK_W     = 2 ** MAX_CODE_W;

  // Returns {disc, stolen}. An item is stolen only when its code is in the
  // stolen set and it carries no secret (paid) mark.
  function automatic logic [1:0] classify(
    input logic [MAX_CODE_W-1:0] code,
    input logic                  mark,
    input logic [MASK_W-1:0]     disc_mask,
    input logic [MASK_W-1:0]     stolen_mask
  );
    return {disc_mask[code], stolen_mask[code] & ~mark};
  endfunction

endpackage

// File: rtl/upc_classify.sv
// upc_classify: combinational per-item classifier.
//   code   (in,  CODE_W) product code
//   mark   (in,  1)      secret mark, 1 = paid/authorised
//   disc   (out, 1)      code is discounted
//   stolen (out, 1)      code is in the stolen set and unmarked
// With the default masks this reproduces the lab's LEDR[0]/LEDR[1] equations.
module upc_classify import upc_pkg::*; #(
  parameter int                    CODE_W      = 3,
  parameter logic [2**CODE_W-1:0] DISC_MASK   = DEF_DISC_MASK,
  parameter logic [2**CODE_W-1:0] STOLEN_MASK = DEF_STOLEN_MASK
) (
  input  logic [CODE_W-1:0] code,
  input  logic              mark,
  output logic              disc,
  output logic              stolen
);

  logic [1:0] res;

  always_comb begin
    res = classify(MAX_CODE_W'(code), mark, MASK_W'(DISC_MASK), MASK_W'(STOLEN_MASK));
  end

  assign disc   = res[1];
  assign stolen = res[0];

endmodule

// File: rtl/upc_checkout.sv
// upc_checkout: sequential UPC checkout accumulator.
//   clk, reset            clock, synchronous active-high reset
//   start/finish/ack      open transaction / close it / consumer read totals
//   in_valid/in_ready     item handshake; in_code, in_mark item payload
//   item_vld/disc/stolen  per-item result, exactly one cycle after accept
//   item/disc/stolen_count running transaction totals (CNT_W bits)
//   full                  item_count has reached MAX_ITEMS
//   alarm                 sticky: a stolen item was seen this transaction
//   done_valid            totals are final and held (DONE state)
//   state_o               FSM state: 0 IDLE, 1 SCAN, 2 DONE
module upc_checkout import upc_pkg::*; #(
  parameter int                    CODE_W      = 3,
  parameter logic [2**CODE_W-1:0] DISC_MASK   = DEF_DISC_MASK,
  parameter logic [2**CODE_W-1:0] STOLEN_MASK = DEF_STOLEN_MASK,
  parameter int                    MAX_ITEMS   = 15,
  localparam int                   CNT_W       = $clog2(MAX_ITEMS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              ack,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_mark,
  output logic              item_vld,
  output logic              item_disc,
  output logic              item_stolen,
  output logic [CNT_W-1:0]  item_count,
  output logic [CNT_W-1:0]  disc_count,
  output logic [CNT_W-1:0]  stolen_count,
  output logic              full,
  output logic              alarm,
  output logic              done_valid,
  output logic [1:0]        state_o
);

  state_t state, state_nx;
  logic   accept;
  logic   take;    // accept that actually updates totals (not dropped by restart)
  logic   clear;   // wipe totals and alarm for a fresh transaction
  logic   cls_disc, cls_stolen;

  upc_classify #(
    .CODE_W      (CODE_W),
    .DISC_MASK   (DISC_MASK),
    .STOLEN_MASK (STOLEN_MASK)
  ) u_classify (
    .code   (in_code),
    .mark   (in_mark),
    .disc   (cls_disc),
    .stolen (cls_stolen)
  );

  // in_ready depends only on registered state, never on in_valid.
  assign full       = (item_count == CNT_W'(MAX_ITEMS));
  assign in_ready   = (state == SCAN) && !full;
  assign accept     = in_valid && in_ready;
  assign done_valid = (state == DONE);
  assign state_o    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          clear    = 1'b1;
        end
      end
      SCAN: begin
        // A restart wins over both a same-cycle item and a same-cycle finish.
        if (start) begin
          clear = 1'b1;
        end else begin
          take = accept;
          if (finish) begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (ack) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Totals and the one-cycle item result stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      item_count   <= '0;
      disc_count   <= '0;
      stolen_count <= '0;
      alarm        <= 1'b0;
      item_vld     <= 1'b0;
      item_disc    <= 1'b0;
      item_stolen  <= 1'b0;
    end else begin
      item_vld    <= take;
      item_disc   <= take & cls_disc;
      item_stolen <= take & cls_stolen;
      if (clear) begin
        item_count   <= '0;
        disc_count   <= '0;
        stolen_count <= '0;
        alarm        <= 1'b0;
      end else if (take) begin
        item_count   <= item_count + CNT_W'(1);
        disc_count   <= disc_count + CNT_W'(cls_disc);
        stolen_count <= stolen_count + CNT_W'(cls_stolen);
        alarm        <= alarm | cls_stolen;
      end
    end
  end

endmodule

// File: tb/tb_upc_checkout.sv
module tb_upc_checkout;

  localparam int         MAXI = 15;
  localparam logic [7:0] DM   = 8'hEC;
  localparam logic [7:0] SM   = 8'h31;

  logic       clk = 1'b0;
  logic       reset, start, finish, ack, in_valid, in_mark;
  logic [2:0] in_code;
  logic       in_ready, item_vld, item_disc, item_stolen, full, alarm, done_valid;
  logic [3:0] item_count, disc_count, stolen_count;
  logic [1:0] state_o;

  logic       c_start, c_finish, c_ack, c_valid, c_mark;
  logic [1:0] c_code;
  logic       c_ready, c_vld, c_disc, c_stolen, c_full, c_alarm, c_done;
  logic [1:0] c_count, c_dcount, c_scount, c_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  upc_checkout dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .ack(ack),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_mark(in_mark),
    .item_vld(item_vld), .item_disc(item_disc), .item_stolen(item_stolen),
    .item_count(item_count), .disc_count(disc_count), .stolen_count(stolen_count),
    .full(full), .alarm(alarm), .done_valid(done_valid), .state_o(state_o)
  );

  upc_checkout #(.CODE_W(2), .DISC_MASK(4'h1), .STOLEN_MASK(4'h8), .MAX_ITEMS(3)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .finish(c_finish), .ack(c_ack),
    .in_valid(c_valid), .in_ready(c_ready), .in_code(c_code), .in_mark(c_mark),
    .item_vld(c_vld), .item_disc(c_disc), .item_stolen(c_stolen),
    .item_count(c_count), .disc_count(c_dcount), .stolen_count(c_scount),
    .full(c_full), .alarm(c_alarm), .done_valid(c_done), .state_o(c_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction phase (0 idle, 1 scanning, 2 closed) plus
  // the totals and the result of the last accepted item.
  int m_ph = 0, m_cnt = 0, m_dc = 0, m_sc = 0;
  bit m_iv = 0, m_id = 0, m_is = 0, m_acc;

  always @(posedge clk) begin
    m_acc = (m_ph == 1) && (m_cnt < MAXI) && in_valid;
    if (reset) begin
      m_ph = 0; m_cnt = 0; m_dc = 0; m_sc = 0;
      m_iv = 0; m_id = 0; m_is = 0;
    end else begin
      m_iv = 0; m_id = 0; m_is = 0;
      if (m_ph == 0) begin
        if (start) begin
          m_ph = 1; m_cnt = 0; m_dc = 0; m_sc = 0;
        end
      end else if (m_ph == 1) begin
        if (start) begin
          m_cnt = 0; m_dc = 0; m_sc = 0;
        end else begin
          if (m_acc) begin
            m_iv = 1;
            m_id = DM[in_code];
            m_is = SM[in_code] && !in_mark;
            m_cnt++;
            m_dc += int'(m_id);
            m_sc += int'(m_is);
          end
          if (finish) m_ph = 2;
        end
      end else if (ack) begin
        m_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 32'(in_ready), 32'((m_ph == 1) && (m_cnt < MAXI)));
      chk("item_vld", 32'(item_vld), 32'(m_iv));
      if (m_iv) begin
        chk("item_disc", 32'(item_disc), 32'(m_id));
        chk("item_stolen", 32'(item_stolen), 32'(m_is));
      end
      chk("item_count", 32'(item_count), 32'(m_cnt));
      chk("disc_count", 32'(disc_count), 32'(m_dc));
      chk("stolen_count", 32'(stolen_count), 32'(m_sc));
      chk("full", 32'(full), 32'(m_cnt == MAXI));
      chk("alarm", 32'(alarm), 32'(m_sc > 0));
      chk("done_valid", 32'(done_valid), 32'(m_ph == 2));
      chk("state_o", 32'(state_o), 32'(m_ph));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    start = 0; finish = 0; ack = 0;
    c_start = 0; c_finish = 0; c_ack = 0;
  endtask

  task automatic item(input logic [2:0] code, input logic mark);
    tick;
    in_valid = 1; in_code = code; in_mark = mark;
  endtask

  function automatic bit led_disc(input logic [2:0] c);
    return c[1] | (c[2] & c[0]);
  endfunction

  function automatic bit led_stolen(input logic [2:0] c, input logic m);
    return ~c[1] & (c[2] | ~c[0]) & ~m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] pat;
    reset = 1; start = 0; finish = 0; ack = 0; in_valid = 0; in_code = 0; in_mark = 0;
    c_start = 0; c_finish = 0; c_ack = 0; c_valid = 0; c_code = 0; c_mark = 0;
    tick;
    chk_on = 1;
    tick;
    reset = 0;
    @(negedge clk);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_count", 32'(item_count), 0);
    chk("rst_done", 32'(done_valid), 0);

    // Exhaustive {code, mark} sweep with default masks.
    tick; start = 1;
    for (int i = 0; i < 16; i++) begin
      pat = 4'(i);
      item(pat[3:1], pat[0]);
      @(negedge clk);
      if (i > 0) begin
        pat = 4'(i - 1);
        chk("led0_disc", 32'(item_disc), 32'(led_disc(pat[3:1])));
        chk("led1_stolen", 32'(item_stolen), 32'(led_stolen(pat[3:1], pat[0])));
      end
    end
    tick; in_valid = 0;
    @(negedge clk);
    chk("sweep_16th_blocked", 32'(item_vld), 0);
    tick; finish = 1;
    tick;
    @(negedge clk);
    // Item 15 ({7,1}) is held off by full, so 15 items: disc codes 2,3,5,6 twice + 7 once.
    chk("sweep_count", 32'(item_count), 15);
    chk("sweep_disc", 32'(disc_count), 9);
    chk("sweep_stolen", 32'(stolen_count), 3);
    chk("sweep_alarm", 32'(alarm), 1);
    chk("sweep_done", 32'(done_valid), 1);

    // Full boundary: 17 back-to-back items.
    tick; ack = 1;
    tick; start = 1;
    for (int i = 0; i < 17; i++) item(3'($urandom), 1'($urandom));
    tick; in_valid = 0;
    @(negedge clk);
    chk("full_count", 32'(item_count), 15);
    chk("full_flag", 32'(full), 1);
    chk("full_ready", 32'(in_ready), 0);

    // Simultaneous finish + accept of code 010.
    tick; finish = 1;
    tick; ack = 1;
    tick; start = 1;
    item(3'd0, 1'b1);
    item(3'd1, 1'b1);
    item(3'd2, 1'b1); finish = 1;
    tick; in_valid = 0;
    @(negedge clk);
    chk("fin_acc_count", 32'(item_count), 3);
    chk("fin_acc_disc", 32'(disc_count), 1);
    chk("fin_acc_state", 32'(state_o), 2);
    chk("fin_acc_done", 32'(done_valid), 1);

    // DONE ignores start; ack returns to IDLE with totals held.
    tick; start = 1;
    @(negedge clk);
    chk("done_ign_start", 32'(state_o), 2);
    tick; ack = 1;
    tick;
    @(negedge clk);
    chk("ack_state", 32'(state_o), 0);
    chk("ack_done", 32'(done_valid), 0);
    chk("ack_held_count", 32'(item_count), 3);

    // Restart mid-SCAN after 4 items; the same-cycle item is dropped.
    tick; start = 1;
    item(3'd0, 1'b0);
    item(3'd4, 1'b0);
    item(3'd1, 1'b1);
    item(3'd2, 1'b1);
    item(3'd0, 1'b0); start = 1;
    tick; in_valid = 0;
    @(negedge clk);
    chk("restart_count", 32'(item_count), 0);
    chk("restart_alarm", 32'(alarm), 0);
    chk("restart_state", 32'(state_o), 1);

    // Reset mid-SCAN after 3 items including 1 stolen.
    item(3'd0, 1'b0);
    item(3'd7, 1'b1);
    item(3'd1, 1'b1);
    tick; in_valid = 1; in_code = 3'd0; in_mark = 0; reset = 1;
    @(negedge clk);
    chk("pre_rst_count", 32'(item_count), 3);
    chk("pre_rst_alarm", 32'(alarm), 1);
    tick; reset = 0; in_valid = 0;
    @(negedge clk);
    chk("midrst_state", 32'(state_o), 0);
    chk("midrst_count", 32'(item_count), 0);
    chk("midrst_alarm", 32'(alarm), 0);
    chk("midrst_ready", 32'(in_ready), 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      tick;
      start    = ($urandom % 16) == 0;
      finish   = ($urandom % 12) == 0;
      ack      = ($urandom % 4) == 0;
      in_valid = ($urandom % 3) != 0;
      in_code  = 3'($urandom);
      in_mark  = 1'($urandom);
      reset    = ($urandom % 150) == 0;
    end
    tick; in_valid = 0; reset = 0;

    // Custom masks on the CODE_W = 2 instance.
    tick; c_start = 1;
    tick; c_valid = 1; c_code = 2'd3; c_mark = 0;
    tick; c_code = 2'd3; c_mark = 1;
    @(negedge clk);
    chk("c_item1_vld", 32'(c_vld), 1);
    chk("c_item1_stolen", 32'(c_stolen), 1);
    chk("c_item1_disc", 32'(c_disc), 0);
    tick; c_code = 2'd0; c_mark = 1;
    @(negedge clk);
    chk("c_item2_stolen", 32'(c_stolen), 0);
    tick; c_valid = 0; c_finish = 1;
    @(negedge clk);
    chk("c_item3_disc", 32'(c_disc), 1);
    chk("c_item3_stolen", 32'(c_stolen), 0);
    chk("c_full", 32'(c_full), 1);
    tick;
    @(negedge clk);
    chk("c_count", 32'(c_count), 3);
    chk("c_dcount", 32'(c_dcount), 1);
    chk("c_scount", 32'(c_scount), 1);
    chk("c_alarm", 32'(c_alarm), 1);
    chk("c_state", 32'(c_state), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
